mux_arb: RTL and testbench

MUX_ARB -- requirements
Module: mux_arb

---
 rtl/mux_pkg.sv | 13 +
 rtl/mux_arb_if.sv | 25 ++
 rtl/mux_rr_grant.sv | 28 ++
 rtl/mux_arb.sv | 88 ++++++++
 tb/tb_mux_arb.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// Shared types and default parameters for the mux_arb channel arbiter.
package mux_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

  localparam int unsigned DEF_WIDTH  = 4;
  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned DEF_CNT_W  = 16;

endpackage

// File: rtl/mux_arb_if.sv
// Per-channel input handshake plus registered output handshake of mux_arb.
interface mux_arb_if #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned NUM_CH = 4
);
  localparam int unsigned SEL_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0][WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]            in_valid;
  logic [NUM_CH-1:0]            in_ready;
  logic [WIDTH-1:0]             out_data;
  logic [SEL_W-1:0]             out_ch;
  logic                         out_valid;
  logic                         out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/mux_rr_grant.sv
// Round-robin search: first valid channel at or above ptr, wrapping to 0.
module mux_rr_grant #(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         valid,
  input  logic [$clog2(NUM_CH)-1:0] ptr,
  output logic [$clog2(NUM_CH)-1:0] grant,
  output logic                      grant_vld
);
  localparam int unsigned PTR_W = $clog2(NUM_CH);

  int unsigned idx;

  // Scan offsets from farthest to nearest so the nearest valid channel wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
      idx = (32'(ptr) + 32'(k)) % NUM_CH;
      if (valid[PTR_W'(idx)]) begin
        grant     = PTR_W'(idx);
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arb.sv
// N-channel to 1 registered mux with direct-select or round-robin arbitration.
module mux_arb
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [$clog2(NUM_CH)-1:0] sel,
  mux_arb_if.slave                  bus,
  output logic [CNT_W-1:0]          xfer_cnt
);
  localparam int unsigned SEL_W = $clog2(NUM_CH);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_vld;
  logic             dir_vld;
  logic [SEL_W-1:0] grant;
  logic             grant_vld;
  logic             accept_c;
  logic             xfer_c;
  logic             is_rr;

  assign is_rr = (mode_e'(mode) == MODE_RR);

  mux_rr_grant #(.NUM_CH(NUM_CH)) u_rr_grant (
    .valid     (bus.in_valid),
    .ptr       (rr_ptr),
    .grant     (rr_grant),
    .grant_vld (rr_vld)
  );

  // Direct select; a sel outside the channel range never matches.
  always_comb begin
    dir_vld = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (sel == SEL_W'(i)) dir_vld = bus.in_valid[i];
    end
  end

  always_comb begin
    grant     = is_rr ? rr_grant : sel;
    grant_vld = is_rr ? rr_vld : dir_vld;
    accept_c  = !bus.out_valid || bus.out_ready;
    xfer_c    = grant_vld && accept_c;
    bus.in_ready = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      bus.in_ready[i] = xfer_c && (grant == SEL_W'(i));
    end
  end

  // Output register: a transfer reloads even while popping, giving full throughput.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
    end else if (xfer_c) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= bus.in_data[grant];
      bus.out_ch    <= grant;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (xfer_c && is_rr) begin
      rr_ptr <= (grant == SEL_W'(NUM_CH - 1)) ? '0 : grant + SEL_W'(1);
    end
  end

  // Saturating transfer counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (xfer_c && (xfer_cnt != '1)) begin
      xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mux_arb.sv
// Directed plus randomized bench for mux_arb against a transaction-level model.
module tb_mux_arb;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_s;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_valid;
  logic [3:0]  m_data;
  int          m_ch;
  int          m_ptr;
  int          m_cnt;
  int          m_cnt_s;

  mux_arb_if #(.WIDTH(4), .NUM_CH(N)) bus_a ();
  mux_arb_if #(.WIDTH(4), .NUM_CH(N)) bus_b ();

  assign bus_b.in_data   = bus_a.in_data;
  assign bus_b.in_valid  = bus_a.in_valid;
  assign bus_b.out_ready = bus_a.out_ready;

  mux_arb dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .bus(bus_a), .xfer_cnt(cnt_a)
  );

  mux_arb #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .bus(bus_b), .xfer_cnt(cnt_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_valid = 0; m_data = '0; m_ch = 0; m_ptr = 0; m_cnt = 0; m_cnt_s = 0;
  endfunction

  // Grant decided purely from the arbitration rules.
  function automatic void model_grant(output bit gv, output int g);
    gv = 0; g = 0;
    if (mode == 1'b0) begin
      if (int'(sel) < N && bus_a.in_valid[sel]) begin gv = 1; g = int'(sel); end
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!gv && bus_a.in_valid[c]) begin gv = 1; g = c; end
      end
    end
  endfunction

  task automatic check_outputs();
    check("out_valid", 32'(bus_a.out_valid), 32'(m_valid));
    check("out_data",  32'(bus_a.out_data),  32'(m_data));
    check("out_ch",    32'(bus_a.out_ch),    32'(m_ch));
    check("xfer_cnt",  32'(cnt_a),           32'(m_cnt));
    check("rr_ptr",    32'(dut.rr_ptr),      32'(m_ptr));
    check("cnt_small", 32'(cnt_s),           32'(m_cnt_s));
    check("out_ch_s",  32'(bus_b.out_ch),    32'(m_ch));
  endtask

  // One clock: check in_ready between edges, advance model at the edge, check outputs after.
  task automatic step();
    bit gv; int g; bit acc; logic [3:0] exp_rdy;
    #1;
    model_grant(gv, g);
    acc = !m_valid || bus_a.out_ready;
    exp_rdy = (gv && acc) ? 4'(1 << g) : 4'b0;
    check("in_ready", 32'(bus_a.in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (gv && acc) begin
      m_valid = 1; m_data = bus_a.in_data[g]; m_ch = g;
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt_s < 3) m_cnt_s++;
      if (mode == 1'b1) m_ptr = (g + 1) % N;
    end else if (m_valid && bus_a.out_ready) begin
      m_valid = 0;
    end
    #1;
    check_outputs();
  endtask

  initial begin
    int rr_seq [6] = '{0, 1, 2, 3, 0, 1};
    logic [3:0] held;

    model_reset();
    mode = 1'b1; sel = 2'd0;
    bus_a.in_data = 16'h4321; bus_a.in_valid = 4'hF; bus_a.out_ready = 1'b0;

    // Held in reset across edges with valid inputs: nothing may load.
    #12;
    check_outputs();
    #5 rst_n = 1'b1;

    // Direct select of channel 2 on the first edge after reset.
    mode = 1'b0; sel = 2'd2; bus_a.in_valid = 4'b0100; bus_a.in_data = 16'h0A00;
    bus_a.out_ready = 1'b1;
    step();
    check("direct_data", 32'(bus_a.out_data), 32'hA);
    check("direct_ch",   32'(bus_a.out_ch),   32'd2);
    check("direct_cnt",  32'(cnt_a),          32'd1);

    // Round-robin over all-valid inputs.
    mode = 1'b1; bus_a.in_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      bus_a.in_data = 16'($urandom);
      step();
      check("rr_seq", 32'(bus_a.out_ch), 32'(rr_seq[i]));
    end

    // Backpressure: held item must not move, then reload on the pop edge.
    bus_a.out_ready = 1'b0;
    held = bus_a.out_data;
    for (int i = 0; i < 3; i++) begin
      bus_a.in_data = 16'($urandom);
      step();
      check("bp_ready", 32'(bus_a.in_ready), 32'd0);
      check("bp_hold",  32'(bus_a.out_data), 32'(held));
    end
    bus_a.out_ready = 1'b1;
    step();
    check("bp_reload_ch", 32'(bus_a.out_ch), 32'd2);

    // Pointer wrap: grant 2 leaves ptr at 3, then only ch0 valid.
    bus_a.in_valid = 4'b0100;
    step();
    check("wrap_ptr3", 32'(dut.rr_ptr), 32'd3);
    bus_a.in_valid = 4'b0001;
    step();
    check("wrap_ch0",  32'(bus_a.out_ch), 32'd0);
    check("wrap_ptr1", 32'(dut.rr_ptr), 32'd1);

    // Asynchronous reset between edges with a held item.
    bus_a.out_ready = 1'b0; bus_a.in_valid = 4'hF;
    step();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_cnt",   32'(cnt_a),           32'd0);
    @(posedge clk);
    #1;
    check_outputs();
    #2 rst_n = 1'b1;

    // Saturation of the 2-bit counter.
    bus_a.out_ready = 1'b1; bus_a.in_valid = 4'hF; mode = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("sat_small", 32'(cnt_s), 32'd3);
    check("sat_wide",  32'(cnt_a), 32'd5);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      bus_a.in_data   = 16'($urandom);
      bus_a.in_valid  = 4'($urandom);
      bus_a.out_ready = ($urandom_range(0, 3) != 0);
      mode            = 1'($urandom_range(0, 1));
      sel             = 2'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
